// File: rtl/intc_pkg.sv
// intc_pkg: shared FSM states, register map and control bit positions for intc
package intc_pkg;
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
    localparam logic [15:0] INTC_PENDING    = 16'h0000;
    localparam logic [15:0] INTC_MASK       = 16'h0001;
    localparam logic [15:0] INTC_IN_SERVICE = 16'h0002;
    localparam logic [15:0] INTC_VBASE      = 16'h0003;
    localparam logic [15:0] INTC_CTRL       = 16'h0004;
    localparam logic [15:0] INTC_EOI        = 16'h0005;
    localparam int CTRL_GEN_BIT = 0;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: find-first-set over W request bits, index 0 wins
module intc_prio_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);
    assign valid = |req;
    // scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) if (req[i]) idx = 4'(i);
    end
endmodule

// File: rtl/intc.sv
// intc: priority interrupt controller; define INTC_NESTING_EN to allow nested service
module intc
    import intc_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      din,
    input  logic [15:0]      addr,
    input  logic             we,
    output logic [15:0]      dout,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             int_ack,
    output logic             irq,
    output logic [15:0]      vector
);
    state_t state, state_nx;
    logic [N_SRC-1:0] prev, pending, mask, in_service;
    logic [N_SRC-1:0] id_oh, isr_oh, isr_left;
    logic [15:0] vbase;
    logic gen;
    logic [3:0] id, cand_idx, isr_idx;
    logic pend_valid, cand_valid, isr_valid;
    logic wr_eoi, ack_fire, eoi_fire, withdraw, nest;

    intc_prio_enc #(.W(N_SRC)) u_cand (.req(pending & mask), .valid(pend_valid), .idx(cand_idx));
    intc_prio_enc #(.W(N_SRC)) u_isr  (.req(in_service), .valid(isr_valid), .idx(isr_idx));

    assign cand_valid = pend_valid && gen;
    assign wr_eoi     = we && addr == INTC_EOI;
    assign id_oh      = N_SRC'(1) << id;
    assign isr_oh     = N_SRC'(1) << isr_idx;
    assign isr_left   = in_service & ~isr_oh;
    assign withdraw   = !(|(pending & id_oh)) || !(|(mask & id_oh)) || !gen;
`ifdef INTC_NESTING_EN
    assign nest = cand_valid && isr_valid && cand_idx < isr_idx;
`else
    assign nest = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end

    // FSM next state; a withdrawn nested request falls back to the ongoing service
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cand_valid ? ASSERT : IDLE;
            ASSERT:  state_nx = int_ack ? SERVICE : withdraw ? (|in_service ? SERVICE : IDLE) : ASSERT;
            SERVICE: state_nx = wr_eoi ? (|isr_left ? SERVICE : IDLE) : nest ? ASSERT : SERVICE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs and the events they qualify
    always_comb begin
        irq      = state == ASSERT;
        ack_fire = irq && int_ack;
        eoi_fire = state == SERVICE && wr_eoi && isr_valid;
        vector   = irq ? vbase + 16'(id) : '0;
    end

    // register file, edge capture and granted-id latch; a new edge beats a W1C
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev       <= '0;
            pending    <= '0;
            mask       <= '0;
            in_service <= '0;
            vbase      <= '0;
            gen        <= 1'b0;
            id         <= '0;
        end else begin
            prev       <= irq_src;
            pending    <= (pending & ~(we && addr == INTC_PENDING ? din[N_SRC-1:0] : '0)
                           & ~(ack_fire ? id_oh : '0)) | (irq_src & ~prev);
            mask       <= we && addr == INTC_MASK ? din[N_SRC-1:0] : mask;
            in_service <= (in_service | (ack_fire ? id_oh : '0)) & ~(eoi_fire ? isr_oh : '0);
            vbase      <= we && addr == INTC_VBASE ? din : vbase;
            gen        <= we && addr == INTC_CTRL ? din[CTRL_GEN_BIT] : gen;
            id         <= state != ASSERT && state_nx == ASSERT ? cand_idx : id;
        end
    end

    // register read mux; bits above N_SRC read as zero
    always_comb begin
        dout = addr == INTC_PENDING    ? 16'(pending) :
               addr == INTC_MASK       ? 16'(mask) :
               addr == INTC_IN_SERVICE ? 16'(in_service) :
               addr == INTC_VBASE      ? vbase :
               addr == INTC_CTRL       ? 16'(gen) : '0;
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed self-checking bench for intc
module tb_intc;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din, addr, dout, vector;
    logic        we, int_ack, irq;
    logic [7:0]  irq_src;
    int checks = 0;
    int errors = 0;

    intc #(.N_SRC(8)) dut (
        .clk(clk), .rst(rst), .din(din), .addr(addr), .we(we), .dout(dout),
        .irq_src(irq_src), .int_ack(int_ack), .irq(irq), .vector(vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a;
        din = d;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic reg_is(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic ack;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] s);
        irq_src = s;
        tick();
        irq_src = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; din = '0; addr = '0; we = 1'b0; int_ack = 1'b0; irq_src = '0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_irq", {15'b0, irq}, 16'h0);
        check("rst_vector", vector, 16'h0);
        for (int a = 0; a < 7; a++) reg_is($sformatf("rst_reg%0d", a), 16'(a), 16'h0);
        ack();
        reg_is("stray_ack_isr", 16'h2, 16'h0);
        check("stray_ack_irq", {15'b0, irq}, 16'h0);

        wr(16'h1, 16'h0001);
        wr(16'h4, 16'h0001);
        wr(16'h3, 16'h0100);
        reg_is("vbase_rd", 16'h3, 16'h0100);
        reg_is("ctrl_rd", 16'h4, 16'h0001);
        pulse(8'h01);
        check("basic_lat1", {15'b0, irq}, 16'h0);
        tick();
        check("basic_irq", {15'b0, irq}, 16'h1);
        check("basic_vec", vector, 16'h0100);
        ack();
        check("basic_ack_irq", {15'b0, irq}, 16'h0);
        reg_is("basic_isr", 16'h2, 16'h0001);
        reg_is("basic_pend", 16'h0, 16'h0000);
        wr(16'h5, 16'h0000);
        reg_is("basic_eoi", 16'h2, 16'h0000);

        wr(16'h1, 16'h00FF);
        pulse(8'h24);
        tick();
        check("prio_irq", {15'b0, irq}, 16'h1);
        check("prio_vec2", vector, 16'h0102);
        ack();
        reg_is("prio_pend", 16'h0, 16'h0020);
        reg_is("prio_isr", 16'h2, 16'h0004);
        check("prio_wait", {15'b0, irq}, 16'h0);
        wr(16'h5, 16'h0000);
        check("prio_eoi_irq", {15'b0, irq}, 16'h0);
        tick();
        check("prio_irq5", {15'b0, irq}, 16'h1);
        check("prio_vec5", vector, 16'h0105);
        ack();
        wr(16'h5, 16'h0000);
        reg_is("prio_done", 16'h2, 16'h0000);

        wr(16'h1, 16'h0000);
        pulse(8'h08);
        tick();
        reg_is("mask_pend", 16'h0, 16'h0008);
        check("mask_noirq", {15'b0, irq}, 16'h0);
        wr(16'h1, 16'h0008);
        tick();
        check("unmask_irq", {15'b0, irq}, 16'h1);
        check("unmask_vec", vector, 16'h0103);
        wr(16'h0, 16'h0008);
        tick();
        check("withdraw_irq", {15'b0, irq}, 16'h0);
        reg_is("withdraw_pend", 16'h0, 16'h0000);
        tick();
        check("withdraw_idle", {15'b0, irq}, 16'h0);

        irq_src = 8'h02;
        addr = 16'h0;
        din = 16'h0002;
        we = 1'b1;
        tick();
        we = 1'b0;
        irq_src = '0;
        reg_is("set_wins", 16'h0, 16'h0002);
        wr(16'h0, 16'h0002);
        reg_is("w1c_clear", 16'h0, 16'h0000);

        wr(16'h1, 16'h0012);
        pulse(8'h10);
        tick();
        check("nest_irq4", {15'b0, irq}, 16'h1);
        check("nest_vec4", vector, 16'h0104);
        ack();
        reg_is("nest_isr4", 16'h2, 16'h0010);
        pulse(8'h02);
        tick();
`ifdef INTC_NESTING_EN
        check("nest_irq1", {15'b0, irq}, 16'h1);
        check("nest_vec1", vector, 16'h0101);
        ack();
        reg_is("nest_isr12", 16'h2, 16'h0012);
        wr(16'h5, 16'h0000);
        reg_is("nest_eoi1", 16'h2, 16'h0010);
        check("nest_eoi1_irq", {15'b0, irq}, 16'h0);
        wr(16'h5, 16'h0000);
        reg_is("nest_eoi2", 16'h2, 16'h0000);
`else
        check("single_wait", {15'b0, irq}, 16'h0);
        reg_is("single_pend", 16'h0, 16'h0002);
        wr(16'h5, 16'h0000);
        reg_is("single_eoi", 16'h2, 16'h0000);
        tick();
        check("single_irq1", {15'b0, irq}, 16'h1);
        check("single_vec1", vector, 16'h0101);
        ack();
        reg_is("single_isr1", 16'h2, 16'h0002);
        wr(16'h5, 16'h0000);
        reg_is("single_done", 16'h2, 16'h0000);
`endif
        tick();
        check("nest_idle", {15'b0, irq}, 16'h0);

        pulse(8'h02);
        tick();
        check("pre_rst_irq", {15'b0, irq}, 16'h1);
        rst = 1'b0;
        tick();
        check("mid_rst_irq", {15'b0, irq}, 16'h0);
        check("mid_rst_vec", vector, 16'h0000);
        for (int a = 0; a < 6; a++) reg_is($sformatf("mid_rst_reg%0d", a), 16'(a), 16'h0);
        rst = 1'b1;
        tick();
        check("post_rst_irq", {15'b0, irq}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
